// File: rtl/mem_read_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_read_port_arbiter_if
// Bundles the two requester handshakes (fetch port I, data-load port D) and
// the byte-wide memory read port of mem_read_port_arbiter.
//   i_req_* / d_req_*   : request valid/ready, start address, log2 size
//   i_resp_* / d_resp_* : one-cycle response valid and 64-bit LE data
//   raddr / rdata       : memory read address and same-cycle read byte
//   busy / owner        : arbiter status
// Modports:
//   slave  : the arbiter side
//   master : the requester/memory side (testbench or core)
// ---------------------------------------------------------------------------
interface mem_read_port_arbiter_if #(
  parameter int ADDR_W = 64
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic [1:0]        i_req_size;
  logic              i_resp_valid;
  logic [63:0]       i_resp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [1:0]        d_req_size;
  logic              d_resp_valid;
  logic [63:0]       d_resp_data;

  logic [ADDR_W-1:0] raddr;
  logic [7:0]        rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_size,
    input  d_req_valid, d_req_addr, d_req_size,
    input  rdata,
    output i_req_ready, i_resp_valid, i_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output raddr, busy, owner
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_size,
    output d_req_valid, d_req_addr, d_req_size,
    output rdata,
    input  i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  raddr, busy, owner
  );
endinterface

// File: rtl/mem_read_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_port_arbiter
// Shares one byte-wide memory read port between instruction fetch (I) and
// data load (D). A granted request reads 1/2/4/8 consecutive bytes, one per
// cycle, assembles them little-endian into a 64-bit word and returns it with
// a one-cycle valid pulse to the requester that owned the transaction.
// Ties alternate: the requester that did not win last time wins.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset, aborts any transaction
//   bus   : mem_read_port_arbiter_if.slave (requests, responses, memory port,
//           busy/owner status)
// ---------------------------------------------------------------------------
module mem_read_port_arbiter #(
  parameter int ADDR_W    = 64,
  parameter bit TIE_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_read_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_count;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_busy;
  logic              r_i_resp_valid;
  logic              r_d_resp_valid;
  logic [7:0]        r_asm [8];

  logic              w_idle;
  logic              w_i_grant;
  logic              w_d_grant;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_size;
  logic [2:0]        w_last_idx;
  logic              w_last;
  logic [63:0]       w_asm;

  // Grant is combinational in IDLE only; a reset cycle never accepts.
  assign w_idle    = (r_state == ST_IDLE) && !reset;
  // On a tie, the requester that is not last_owner wins.
  assign w_i_grant = w_idle && bus.i_req_valid && (!bus.d_req_valid || r_last_owner);
  assign w_d_grant = w_idle && bus.d_req_valid && (!bus.i_req_valid || !r_last_owner);
  assign w_accept  = w_i_grant || w_d_grant;

  assign w_sel_addr = w_d_grant ? bus.d_req_addr : bus.i_req_addr;
  assign w_sel_size = w_d_grant ? bus.d_req_size : bus.i_req_size;

  // Index of the final byte: (1 << size) - 1.
  always_comb begin
    w_last_idx = 3'd0;
    case (r_size)
      2'd0:    w_last_idx = 3'd0;
      2'd1:    w_last_idx = 3'd1;
      2'd2:    w_last_idx = 3'd3;
      default: w_last_idx = 3'd7;
    endcase
  end

  assign w_last = (r_count == w_last_idx);

  // Control FSM. raddr is kept as a running register (base + count) so the
  // memory address leaves a flop; it wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_count        <= 3'd0;
      r_size         <= 2'd0;
      r_raddr        <= '0;
      r_owner        <= 1'b0;
      r_last_owner   <= ~TIE_FIRST;
      r_busy         <= 1'b0;
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
    end else begin
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_raddr      <= w_sel_addr;
            r_size       <= w_sel_size;
            r_owner      <= w_d_grant;
            r_last_owner <= w_d_grant;
            r_count      <= 3'd0;
            r_busy       <= 1'b1;
            r_state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_last) begin
            r_count        <= 3'd0;
            r_raddr        <= '0;
            r_i_resp_valid <= !r_owner;
            r_d_resp_valid <= r_owner;
            r_state        <= ST_RESP;
          end else begin
            r_count <= r_count + 3'd1;
            r_raddr <= r_raddr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte lanes of the assembly register. Cleared on accept so bytes above
  // the transfer size read back as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset || w_accept) begin
          r_asm[gi] <= 8'h00;
        end else if ((r_state == ST_READ) && (r_count == 3'(gi))) begin
          r_asm[gi] <= bus.rdata;
        end
      end
      assign w_asm[gi*8 +: 8] = r_asm[gi];
    end
  endgenerate

  assign bus.i_req_ready  = w_i_grant;
  assign bus.d_req_ready  = w_d_grant;
  assign bus.i_resp_valid = r_i_resp_valid;
  assign bus.d_resp_valid = r_d_resp_valid;
  // Data holds after RESP until the next accept; only resp_valid qualifies it.
  assign bus.i_resp_data  = w_asm;
  assign bus.d_resp_data  = w_asm;
  assign bus.raddr        = (r_state == ST_READ) ? r_raddr : '0;
  assign bus.busy         = r_busy;
  assign bus.owner        = r_owner;

endmodule

// File: tb/tb_mem_read_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_read_port_arbiter
// Self-checking bench: reset checks, a directed table of transactions with
// hand-computed winners/data, a reset-abort sequence, then randomized
// transactions checked against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_mem_read_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_read_port_arbiter_if #(.ADDR_W(64)) bus ();

  mem_read_port_arbiter #(
    .ADDR_W   (64),
    .TIE_FIRST(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory model: 1 KiB image aliased across the address space.
  logic [7:0] mem [0:1023];
  assign bus.rdata = mem[bus.raddr[9:0]];

  int checks   = 0;
  int failures = 0;
  int txn_no   = 0;
  bit m_last   = 1'b1;  // model last_owner, starts at ~TIE_FIRST

  typedef struct {
    bit          vi;
    bit          vd;
    logic [63:0] ai;
    logic [1:0]  si;
    logic [63:0] ad;
    logic [1:0]  sd;
    int          win;      // 0 = I, 1 = D, 2 = none
    logic [63:0] exp_data;
    bit          has_data;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected response: bytes addr .. addr+2^size-1 packed little-endian.
  function automatic logic [63:0] model_data(input logic [63:0] addr, input logic [1:0] size);
    logic [63:0] d;
    logic [63:0] a;
    d = 64'd0;
    for (int k = 0; k < (1 << size); k++) begin
      a = addr + 64'(k);
      d = d | (64'(mem[a[9:0]]) << (8 * k));
    end
    return d;
  endfunction

  // Fair arbitration rule: single valid wins; on a tie the non-last owner.
  function automatic int model_winner(input bit vi, input bit vd, input bit last);
    if (vi && vd) return last ? 0 : 1;
    if (vi) return 0;
    if (vd) return 1;
    return 2;
  endfunction

  // Entered at a negedge with the DUT in IDLE; returns at the negedge of the
  // following IDLE cycle.
  task automatic run_txn(input bit vi, input bit vd,
                         input logic [63:0] ai, input logic [1:0] si,
                         input logic [63:0] ad, input logic [1:0] sd,
                         input int win, input string tag,
                         output logic [63:0] got);
    logic [63:0] a;
    logic [1:0]  s;
    logic [63:0] exp;
    int          n;
    got = 64'd0;
    bus.i_req_valid = vi;
    bus.i_req_addr  = ai;
    bus.i_req_size  = si;
    bus.d_req_valid = vd;
    bus.d_req_addr  = ad;
    bus.d_req_size  = sd;
    #1;
    chk({tag, " i_ready"}, 64'(bus.i_req_ready), 64'(win == 0));
    chk({tag, " d_ready"}, 64'(bus.d_req_ready), 64'(win == 1));
    chk({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
    if (win == 2) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " no_grant_busy"}, 64'(bus.busy), 64'd0);
      $display("txn %0d %s no request", txn_no, tag);
      return;
    end
    a      = (win == 1) ? ad : ai;
    s      = (win == 1) ? sd : si;
    n      = 1 << s;
    exp    = model_data(a, s);
    m_last = (win == 1);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s raddr[%0d]", tag, k), bus.raddr, a + 64'(k));
      chk({tag, " read_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, " owner"}, 64'(bus.owner), 64'(win));
      chk({tag, " read_ready"}, 64'({bus.i_req_ready, bus.d_req_ready}), 64'd0);
      chk({tag, " read_resp"}, 64'({bus.i_resp_valid, bus.d_resp_valid}), 64'd0);
      // Inputs must be ignored while busy.
      bus.i_req_addr = {$urandom, $urandom};
      bus.i_req_size = 2'($urandom);
      bus.d_req_addr = {$urandom, $urandom};
      bus.d_req_size = 2'($urandom);
    end
    @(negedge clk);
    chk({tag, " resp_valid"}, 64'({bus.i_resp_valid, bus.d_resp_valid}),
        (win == 1) ? 64'd1 : 64'd2);
    got = (win == 1) ? bus.d_resp_data : bus.i_resp_data;
    chk({tag, " resp_data"}, got, exp);
    chk({tag, " resp_raddr"}, bus.raddr, 64'd0);
    chk({tag, " resp_ready"}, 64'({bus.i_req_ready, bus.d_req_ready}), 64'd0);
    @(negedge clk);
    chk({tag, " post_resp"}, 64'({bus.i_resp_valid, bus.d_resp_valid}), 64'd0);
    chk({tag, " post_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " data_hold"}, (win == 1) ? bus.d_resp_data : bus.i_resp_data, exp);
    txn_no++;
    $display("txn %0d %s owner=%0d addr=%h size=%0d data=%h", txn_no, tag, win, a, s, got);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    bit          vi, vd;
    logic [63:0] ai, ad;
    logic [1:0]  si, sd;
    int          w;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h010] = 8'h78; mem[10'h011] = 8'h56;
    mem[10'h012] = 8'h34; mem[10'h013] = 8'h12;
    mem[10'h3FF] = 8'hA5; mem[10'h3FE] = 8'hC3;
    mem[10'h000] = 8'h11; mem[10'h001] = 8'h22;

    bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_req_size = '0;
    bus.d_req_valid = 1'b0; bus.d_req_addr = '0; bus.d_req_size = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy",   64'(bus.busy), 64'd0);
    chk("rst owner",  64'(bus.owner), 64'd0);
    chk("rst raddr",  bus.raddr, 64'd0);
    chk("rst resp",   64'({bus.i_resp_valid, bus.d_resp_valid}), 64'd0);
    chk("rst data",   bus.i_resp_data, 64'd0);
    chk("rst ready",  64'({bus.i_req_ready, bus.d_req_ready}), 64'd0);
    reset = 1'b0;

    // Directed table; winners follow from last_owner = D after reset.
    tbl[0] = '{1'b1, 1'b1, 64'h10,  2'd2, 64'h3FF, 2'd0, 0, 64'h12345678, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 64'h20,  2'd1, 64'h3FF, 2'd0, 1, 64'hA5,       1'b1};
    tbl[2] = '{1'b1, 1'b1, 64'h12,  2'd0, 64'h40,  2'd3, 0, 64'h34,       1'b1};
    tbl[3] = '{1'b0, 1'b1, 64'h0,   2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1, 64'h2211A5C3, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 64'h0,   2'd0, 64'h0,   2'd0, 2, 64'h0,        1'b0};
    tbl[5] = '{1'b1, 1'b0, 64'h100, 2'd3, 64'h0,   2'd0, 0, 64'h0,        1'b0};
    tbl[6] = '{1'b1, 1'b1, 64'h10,  2'd1, 64'h11,  2'd1, 1, 64'h3456,     1'b1};
    tbl[7] = '{1'b0, 1'b1, 64'h0,   2'd0, 64'h3FF, 2'd1, 1, 64'h11A5,     1'b1};
    tbl[8] = '{1'b1, 1'b1, 64'h3FF, 2'd0, 64'h0,   2'd0, 0, 64'hA5,       1'b1};

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].vi, tbl[i].vd, tbl[i].ai, tbl[i].si, tbl[i].ad, tbl[i].sd,
              tbl[i].win, $sformatf("tbl%0d", i), got);
      if (tbl[i].has_data) chk($sformatf("tbl%0d const_data", i), got, tbl[i].exp_data);
    end

    // Reset abort on the 3rd READ cycle of an 8-byte fetch.
    bus.i_req_valid = 1'b1; bus.i_req_addr = 64'h200; bus.i_req_size = 2'd3;
    bus.d_req_valid = 1'b0;
    #1;
    chk("abort accept", 64'(bus.i_req_ready), 64'd1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort raddr[%0d]", k), bus.raddr, 64'h200 + 64'(k));
      if (k == 2) reset = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy",  64'(bus.busy), 64'd0);
    chk("abort resp",  64'({bus.i_resp_valid, bus.d_resp_valid}), 64'd0);
    chk("abort ready", 64'({bus.i_req_ready, bus.d_req_ready}), 64'd2);
    chk("abort owner", 64'(bus.owner), 64'd0);
    bus.i_req_valid = 1'b0;
    #1;
    chk("abort gated", 64'(bus.i_req_ready), 64'd0);
    m_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort no_resp", 64'({bus.i_resp_valid, bus.d_resp_valid}), 64'd0);
    end
    run_txn(1'b1, 1'b1, 64'h10, 2'd2, 64'h3FF, 2'd0, 0, "after_abort", got);
    chk("after_abort const_data", got, 64'h12345678);

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      vi = ($urandom_range(0, 3) != 0);
      vd = ($urandom_range(0, 3) != 0);
      ai = ($urandom_range(0, 4) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                                       : {$urandom, $urandom};
      ad = {$urandom, $urandom};
      si = 2'($urandom);
      sd = 2'($urandom);
      w  = model_winner(vi, vd, m_last);
      run_txn(vi, vd, ai, si, ad, sd, w, $sformatf("rnd%0d", i), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
